add_cs_tree: RTL and testbench

Parametrised, pipelined multi-operand adder for the multiplier datapath. It generalises the fixed three-operand 64-bit carry-save adder to NOPS operands of WIDTH bits, with per-operand subtraction, a register after every 3:2 compressor level, a two-stage split carry-propagate adder and a valid/ready handshake with backpressure. It sits behind the partial-product generator of the signed Booth multiplier and reduces the partial products to one WIDTH-bit result at one result per cycle.

---
 rtl/add_cs_pkg.sv | 44 ++++
 rtl/csa_row.sv | 32 +++
 rtl/add_cs_tree.sv | 202 ++++++++++++++++++++
 tb/tb_add_cs_tree.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/add_cs_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : add_cs_pkg
//  Purpose  : Shared constants and elaboration-time helpers for the
//             carry-save multi-operand adder tree (add_cs_tree).
//             csa_rows()   - row count after a given number of 3:2 levels
//             csa_levels() - number of 3:2 levels needed to reach two rows
//  Revision : 1.0  initial release
// ============================================================================
package add_cs_pkg;

    // Legal parameter bounds for add_cs_tree.
    localparam int c_width_min = 8;
    localparam int c_nops_min  = 3;
    localparam int c_nops_max  = 16;
    localparam int c_tagw_min  = 1;

    // Each level turns every full group of three rows into two rows.
    // Leftover rows pass through, so n -> n - floor(n/3).
    function automatic int csa_rows(input int n, input int lvl);
        int r;
        r = n;
        for (int i = 0; i < lvl; i++) begin
            if (r > 2) begin
                r = r - r / 3;
            end
        end
        return r;
    endfunction

    function automatic int csa_levels(input int n);
        int r;
        int l;
        r = n;
        l = 0;
        while (r > 2) begin
            r = r - r / 3;
            l = l + 1;
        end
        return l;
    endfunction

endpackage
`default_nettype wire

// File: rtl/csa_row.sv
`default_nettype none
// ============================================================================
//  Module   : csa_row
//  Purpose  : One WIDTH-bit row of 3:2 compressors (full adders).
//  Ports    : a, b, c - three addend rows
//             s       - bitwise sum a^b^c
//             cy      - majority(a,b,c) shifted left by one; the majority
//                       MSB falls off the top (results are mod 2^WIDTH)
//  Revision : 1.0  initial release
// ============================================================================
module csa_row #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] cy
);

    // Only the low WIDTH-1 majority bits survive the shift, so the top
    // majority bit is never formed.
    logic [WIDTH-2:0] w_maj;

    assign s     = a ^ b ^ c;
    assign w_maj = (a[WIDTH-2:0] & b[WIDTH-2:0])
                 | (a[WIDTH-2:0] & c[WIDTH-2:0])
                 | (b[WIDTH-2:0] & c[WIDTH-2:0]);
    assign cy    = {w_maj, 1'b0};

endmodule
`default_nettype wire

// File: rtl/add_cs_tree.sv
`default_nettype none
// ============================================================================
//  Module   : add_cs_tree
//  Purpose  : Pipelined NOPS-operand adder with per-operand subtraction.
//             Operands (optionally inverted) plus a popcount(in_neg) row are
//             reduced by registered 3:2 compressor levels down to two rows,
//             then summed by a two-stage split carry-propagate adder.
//             Pipeline depth is csa_levels(NOPS+1) + 2 stages; the whole
//             pipeline advances together whenever the output is empty or
//             being consumed.
//  Ports    : clk, rst_n (synchronous, active-low)
//             in_valid/in_ready, in_ops[NOPS*WIDTH], in_neg[NOPS], in_tag
//             out_valid/out_ready, out_sum[WIDTH], out_tag
//  Revision : 1.0  initial release
// ============================================================================
module add_cs_tree
    import add_cs_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int NOPS  = 8,
    parameter int TAGW  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NOPS*WIDTH-1:0]  in_ops,
    input  logic [NOPS-1:0]        in_neg,
    input  logic [TAGW-1:0]        in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_sum,
    output logic [TAGW-1:0]        out_tag
);

    localparam int c_m      = NOPS + 1;
    localparam int c_levels = csa_levels(c_m);
    localparam int c_hw     = WIDTH / 2;
    localparam int c_pcw    = $clog2(NOPS + 1);

    if ((WIDTH < c_width_min) || ((WIDTH % 2) != 0) ||
        (NOPS < c_nops_min) || (NOPS > c_nops_max) ||
        (TAGW < c_tagw_min)) begin : g_param_chk
        $error("add_cs_tree: illegal parameter combination");
    end

    // ------------------------------------------------------------------
    // Global advance: the pipeline moves as one unit.
    // ------------------------------------------------------------------
    logic w_adv;
    logic r_b_valid;

    assign w_adv     = !r_b_valid | out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_b_valid;

    // ------------------------------------------------------------------
    // Row formation: -x = ~x + 1, with all the +1 terms gathered into a
    // single extra row holding popcount(in_neg).
    // ------------------------------------------------------------------
    logic [c_m-1:0][WIDTH-1:0] w_rows0;
    logic [c_pcw-1:0]          w_pcnt;

    always_comb begin
        w_pcnt = '0;
        for (int i = 0; i < NOPS; i++) begin
            w_pcnt = w_pcnt + c_pcw'(in_neg[i]);
        end
    end

    for (genvar i = 0; i < NOPS; i++) begin : g_opnd
        assign w_rows0[i] = in_neg[i] ? ~in_ops[i*WIDTH +: WIDTH]
                                      :  in_ops[i*WIDTH +: WIDTH];
    end
    assign w_rows0[NOPS] = {{(WIDTH-c_pcw){1'b0}}, w_pcnt};

    // ------------------------------------------------------------------
    // Compressor levels, each followed by a pipeline register.
    // Group g consumes rows 3g..3g+2 and produces rows 2g (sum) and
    // 2g+1 (carry); leftover rows are appended after the pairs.
    // ------------------------------------------------------------------
    for (genvar l = 0; l < c_levels; l++) begin : g_lvl
        localparam int N_IN  = csa_rows(c_m, l);
        localparam int N_OUT = csa_rows(c_m, l + 1);
        localparam int NG    = N_IN / 3;

        logic [N_IN-1:0][WIDTH-1:0]  w_in;
        logic [N_OUT-1:0][WIDTH-1:0] w_out;
        logic                        w_vin;
        logic [TAGW-1:0]             w_tin;

        logic [N_OUT-1:0][WIDTH-1:0] r_rows;
        logic                        r_valid;
        logic [TAGW-1:0]             r_tag;

        if (l == 0) begin : g_src
            assign w_in  = w_rows0;
            assign w_vin = in_valid;
            assign w_tin = in_tag;
        end else begin : g_src
            assign w_in  = g_lvl[l-1].r_rows;
            assign w_vin = g_lvl[l-1].r_valid;
            assign w_tin = g_lvl[l-1].r_tag;
        end

        for (genvar g = 0; g < NG; g++) begin : g_csa
            csa_row #(
                .WIDTH (WIDTH)
            ) u_csa_row (
                .a  (w_in[3*g]),
                .b  (w_in[3*g+1]),
                .c  (w_in[3*g+2]),
                .s  (w_out[2*g]),
                .cy (w_out[2*g+1])
            );
        end

        for (genvar j = 0; j < N_IN - 3*NG; j++) begin : g_pass
            assign w_out[2*NG+j] = w_in[3*NG+j];
        end

        // Bubbles travel like real transactions, so data loads whenever
        // the pipeline advances, regardless of the valid bit.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_rows  <= '0;
                r_valid <= 1'b0;
                r_tag   <= '0;
            end else if (w_adv) begin
                r_rows  <= w_out;
                r_valid <= w_vin;
                r_tag   <= w_tin;
            end
        end
    end

    // ------------------------------------------------------------------
    // CPA stage A: low half of S+C plus the carry into the high half.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] w_c;
    logic             w_tree_valid;
    logic [TAGW-1:0]  w_tree_tag;
    logic [c_hw:0]    w_lo;

    assign w_s          = g_lvl[c_levels-1].r_rows[0];
    assign w_c          = g_lvl[c_levels-1].r_rows[1];
    assign w_tree_valid = g_lvl[c_levels-1].r_valid;
    assign w_tree_tag   = g_lvl[c_levels-1].r_tag;
    assign w_lo         = {1'b0, w_s[c_hw-1:0]} + {1'b0, w_c[c_hw-1:0]};

    logic                  r_a_valid;
    logic [TAGW-1:0]       r_a_tag;
    logic [c_hw-1:0]       r_a_lo;
    logic                  r_a_cy;
    logic [WIDTH-c_hw-1:0] r_a_shi;
    logic [WIDTH-c_hw-1:0] r_a_chi;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_valid <= 1'b0;
            r_a_tag   <= '0;
            r_a_lo    <= '0;
            r_a_cy    <= 1'b0;
            r_a_shi   <= '0;
            r_a_chi   <= '0;
        end else if (w_adv) begin
            r_a_valid <= w_tree_valid;
            r_a_tag   <= w_tree_tag;
            r_a_lo    <= w_lo[c_hw-1:0];
            r_a_cy    <= w_lo[c_hw];
            r_a_shi   <= w_s[WIDTH-1:c_hw];
            r_a_chi   <= w_c[WIDTH-1:c_hw];
        end
    end

    // ------------------------------------------------------------------
    // CPA stage B: high half with the stage-A carry; final carry dropped.
    // ------------------------------------------------------------------
    logic [WIDTH-c_hw-1:0] w_hi;
    logic [TAGW-1:0]       r_b_tag;
    logic [WIDTH-1:0]      r_b_sum;

    assign w_hi = r_a_shi + r_a_chi + (WIDTH-c_hw)'(r_a_cy);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_b_valid <= 1'b0;
            r_b_tag   <= '0;
            r_b_sum   <= '0;
        end else if (w_adv) begin
            r_b_valid <= r_a_valid;
            r_b_tag   <= r_a_tag;
            r_b_sum   <= {w_hi, r_a_lo};
        end
    end

    assign out_sum = r_b_sum;
    assign out_tag = r_b_tag;

endmodule
`default_nettype wire

// File: tb/tb_add_cs_tree.sv
`default_nettype none
// ============================================================================
//  Module   : tb_add_cs_tree
//  Purpose  : Directed self-checking bench for add_cs_tree
//             (WIDTH=64, NOPS=8, TAGW=4, pipeline depth 6).
//  Revision : 1.0  initial release
// ============================================================================
module tb_add_cs_tree;

    localparam int WIDTH = 64;
    localparam int NOPS  = 8;
    localparam int TAGW  = 4;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  in_valid;
    logic                  in_ready;
    logic [NOPS*WIDTH-1:0] in_ops;
    logic [NOPS-1:0]       in_neg;
    logic [TAGW-1:0]       in_tag;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_sum;
    logic [TAGW-1:0]       out_tag;

    always #5 clk = ~clk;

    add_cs_tree #(
        .WIDTH (WIDTH),
        .NOPS  (NOPS),
        .TAGW  (TAGW)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ops    (in_ops),
        .in_neg    (in_neg),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_tag   (out_tag)
    );

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [63:0] op [NOPS];
    logic [63:0] exp_sum_q [$];
    logic [3:0]  exp_tag_q [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_ops();
        for (int i = 0; i < NOPS; i++) begin
            op[i] = 64'd0;
        end
    endtask

    // Reference: signed/unsigned sum modulo 2^64.
    function automatic logic [63:0] ref_sum(input logic [NOPS-1:0] neg);
        logic [63:0] s;
        s = 64'd0;
        for (int i = 0; i < NOPS; i++) begin
            s = neg[i] ? (s - op[i]) : (s + op[i]);
        end
        return s;
    endfunction

    task automatic load(input logic [NOPS-1:0] neg, input logic [3:0] tag);
        for (int i = 0; i < NOPS; i++) begin
            in_ops[i*WIDTH +: WIDTH] = op[i];
        end
        in_neg   = neg;
        in_tag   = tag;
        in_valid = 1'b1;
    endtask

    // Single transaction into an empty pipeline with out_ready=1.
    // Called just after a rising edge; the next edge accepts it.
    task automatic run1(input string name, input logic [NOPS-1:0] neg,
                        input logic [3:0] tag, input logic [63:0] exp);
        load(neg, tag);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk({name, "_early"}, 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        chk({name, "_valid"}, 64'(out_valid), 64'd1);
        chk({name, "_sum"},   out_sum, exp);
        chk({name, "_tag"},   64'(out_tag), 64'(tag));
        @(posedge clk); #1;
    endtask

    initial begin
        int          rcv;
        int          cyc;
        int          seen;
        logic        held;
        logic [63:0] hsum;
        logic [3:0]  htag;
        logic [NOPS-1:0] nb;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_ops    = '0;
        in_neg    = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        clr_ops();

        // ---------------- reset ----------------
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_sum",   out_sum,        64'd0);
        chk("rst_out_tag",   64'(out_tag),   64'd0);

        // ---------------- directed vectors ----------------
        for (int i = 0; i < NOPS; i++) op[i] = 64'd1;
        run1("ones", 8'h00, 4'd3, 64'd8);

        for (int i = 0; i < NOPS; i++) op[i] = 64'hFFFF_FFFF_FFFF_FFFF;
        run1("allf", 8'h00, 4'd5, 64'hFFFF_FFFF_FFFF_FFF8);

        clr_ops();
        op[0] = 64'h0000_0000_FFFF_FFFF;
        op[1] = 64'd1;
        run1("halfcarry", 8'h00, 4'd6, 64'h0000_0001_0000_0000);

        clr_ops();
        op[0] = 64'd100;
        op[1] = 64'd30;
        run1("sub70", 8'h02, 4'd7, 64'd70);

        clr_ops();
        op[1] = 64'd1;
        run1("negone", 8'h02, 4'd8, 64'hFFFF_FFFF_FFFF_FFFF);

        for (int i = 0; i < NOPS; i++) op[i] = 64'd1;
        run1("allneg", 8'hFF, 4'd15, 64'hFFFF_FFFF_FFFF_FFF8);

        // ---------------- streaming with backpressure ----------------
        rcv  = 0;
        cyc  = 0;
        held = 1'b0;
        hsum = 64'd0;
        htag = 4'd0;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    logic acc;
                    int   tries;
                    for (int k = 0; k < NOPS; k++) op[k] = {$urandom, $urandom};
                    nb = NOPS'($urandom);
                    exp_sum_q.push_back(ref_sum(nb));
                    exp_tag_q.push_back(4'(i));
                    load(nb, 4'(i));
                    acc   = 1'b0;
                    tries = 0;
                    while (!acc && tries < 200) begin
                        @(negedge clk);
                        acc = in_ready;
                        @(posedge clk); #1;
                        tries++;
                    end
                end
                in_valid = 1'b0;
            end
            begin
                while (rcv < 20 && cyc < 600) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                    cyc++;
                    @(negedge clk);
                    if (held) begin
                        chk("stall_valid", 64'(out_valid), 64'd1);
                        chk("stall_sum",   out_sum,        hsum);
                        chk("stall_tag",   64'(out_tag),   64'(htag));
                    end
                    held = 1'b0;
                    if (out_valid) begin
                        if (out_ready) begin
                            if (exp_sum_q.size() > 0) begin
                                chk("stream_sum", out_sum,      exp_sum_q.pop_front());
                                chk("stream_tag", 64'(out_tag), 64'(exp_tag_q.pop_front()));
                            end else begin
                                chk("stream_extra", 64'(out_valid), 64'd0);
                            end
                            rcv++;
                        end else begin
                            held = 1'b1;
                            hsum = out_sum;
                            htag = out_tag;
                        end
                    end
                end
            end
        join
        chk("stream_count", 64'(rcv), 64'd20);

        @(posedge clk); #1;
        out_ready = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("stream_tail", 64'(seen), 64'd0);

        // ---------------- reset flush ----------------
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            clr_ops();
            op[0] = 64'(100 + i);
            load(8'h00, 4'(10 + i));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("flush_valid", 64'(out_valid), 64'd0);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("flush_none", 64'(seen), 64'd0);

        // Pipeline works again after the flush.
        @(posedge clk); #1;
        clr_ops();
        op[3] = 64'd5;
        op[6] = 64'd9;
        run1("recover", 8'h40, 4'd9, 64'hFFFF_FFFF_FFFF_FFFC);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
